// File: rtl/asym_upsize_fifo.sv
// Narrow-write / wide-read FIFO. IN_WIDTH beats are packed LSB-first into
// OUT_WIDTH words, buffered in an OUT_DEPTH-entry memory and presented to a
// wide consumer through a registered read stage plus a one-word output
// register. The read stage and the output register together form a two-deep
// prefetch, so pops run back to back without bubbles.
module asym_upsize_fifo #(
  parameter  int IN_WIDTH  = 32,
  parameter  int OUT_WIDTH = 64,
  parameter  int OUT_DEPTH = 512,
  localparam int CNT_W     = $clog2(OUT_DEPTH) + 1
) (
  input  logic                 core_clk,
  input  logic                 resetn,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     count
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int ADDR_W = $clog2(OUT_DEPTH);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(OUT_DEPTH);

  logic [LANE_W-1:0]    lane_q;
  logic [OUT_WIDTH-1:0] asm_q;
  logic [OUT_WIDTH-1:0] asm_next;

  // Pointers carry one extra bit so equal pointers unambiguously mean empty.
  logic [CNT_W-1:0]     wr_ptr;
  logic [CNT_W-1:0]     rd_ptr;

  logic [OUT_WIDTH-1:0] mem [OUT_DEPTH];
  logic [OUT_WIDTH-1:0] rd_data_q;
  logic                 rd_vld_q;

  logic accept;
  logic commit;
  logic pop;
  logic mem_empty;
  logic move;
  logic issue;

  // Count covers every committed word, including those already in the read
  // stage or output register, so it alone bounds memory occupancy.
  assign in_ready  = resetn && (count < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign commit    = accept && (in_last || (lane_q == LAST_LANE));
  assign pop       = out_valid && out_ready;
  assign mem_empty = (wr_ptr == rd_ptr);

  // Read stage advances into the output register whenever that register is
  // free or being emptied; a new read is issued whenever the read stage will
  // be free after this edge.
  assign move  = rd_vld_q && (!out_valid || out_ready);
  assign issue = !mem_empty && (!rd_vld_q || move);

  // Merge the incoming beat into its lane; lanes above stay zero because the
  // assembly register is cleared on every commit.
  always_comb begin
    asm_next = asm_q;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == LANE_W'(i)) begin
        asm_next[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  // Storage array and its registered read port; intentionally not reset.
  always_ff @(posedge core_clk) begin
    if (commit) begin
      mem[wr_ptr[ADDR_W-1:0]] <= asm_next;
    end
    if (issue) begin
      rd_data_q <= mem[rd_ptr[ADDR_W-1:0]];
    end
  end

  // Packing, pointers, occupancy and output stage.
  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      lane_q    <= '0;
      asm_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_vld_q  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (accept) begin
        if (commit) begin
          lane_q <= '0;
          asm_q  <= '0;
          wr_ptr <= wr_ptr + CNT_W'(1);
        end else begin
          lane_q <= lane_q + LANE_W'(1);
          asm_q  <= asm_next;
        end
      end

      case ({commit, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (issue) begin
        rd_ptr   <= rd_ptr + CNT_W'(1);
        rd_vld_q <= 1'b1;
      end else if (move) begin
        rd_vld_q <= 1'b0;
      end

      if (move) begin
        out_data  <= rd_data_q;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_asym_upsize_fifo.sv
// Bench for asym_upsize_fifo (32-bit beats into 64-bit words, 512 deep).
// A packing model pushes expected words as beats are accepted; a monitor
// pops and compares them as the DUT pops words, and checks hold on stalls.
module tb_asym_upsize_fifo;

  localparam int IW    = 32;
  localparam int OW    = 64;
  localparam int DEPTH = 512;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          core_clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] tb_asm  = '0;
  int            tb_lane = 0;

  bit            prev_stall = 1'b0;
  logic [OW-1:0] prev_data  = '0;

  asym_upsize_fifo #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .OUT_DEPTH(DEPTH)) dut (
    .core_clk (core_clk),
    .resetn   (resetn),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count)
  );

  always #5 core_clk = ~core_clk;

  // Scoreboard compare on every pop, plus output hold during stalls.
  always @(negedge core_clk) begin
    logic [OW-1:0] exp;
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: out_valid=%b out_data=%h required 1 %h",
                   out_valid, out_data, prev_data);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: got %h required no word", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("FAIL scoreboard: got %h required %h", out_data, exp);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_data  = out_data;
    end
  end

  task automatic model_accept(input logic [IW-1:0] d, input logic l);
    if (tb_lane == 0) tb_asm[31:0] = d;
    else              tb_asm[63:32] = d;
    if (tb_lane == 1 || l) begin
      exp_q.push_back(tb_asm);
      tb_asm  = '0;
      tb_lane = 0;
    end else begin
      tb_lane = 1;
    end
  endtask

  // Present one beat until accepted; starts and ends 1 ns after a rising edge.
  task automatic send(input logic [IW-1:0] d, input logic l);
    bit ok = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge core_clk);
      if (in_ready) begin
        model_accept(d, l);
        ok = 1'b1;
      end
      @(posedge core_clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat %h never accepted", d);
    end
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge core_clk);
      if (count == 0 && !out_valid && exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL drain: count=%0d queued=%0d required 0 0", count, exp_q.size());
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b count=%0d out_data=%h required 0 0 0 0",
               in_ready, out_valid, count, out_data);
    end
    @(posedge core_clk);
    #1;
    resetn = 1'b1;
    @(negedge core_clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_pack_full_word();
    out_ready = 1'b1;
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    @(negedge core_clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge1: out_valid=%b required 0", out_valid);
    end
    @(negedge core_clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge2: out_valid=%b required 0", out_valid);
    end
    @(negedge core_clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000022_00000011) begin
      errors++;
      $display("FAIL pack_word: out_valid=%b out_data=%h required 1 0000002200000011",
               out_valid, out_data);
    end
    @(negedge core_clk);
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL count_after_pop: count=%0d required 0", count);
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_last_early();
    out_ready = 1'b1;
    send(32'hAA, 1'b1);
    @(negedge core_clk);
    @(negedge core_clk);
    @(negedge core_clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000000_000000AA) begin
      errors++;
      $display("FAIL last_lane0: out_valid=%b out_data=%h required 1 00000000000000aa",
               out_valid, out_data);
    end
    @(posedge core_clk);
    #1;
    // A stray in_last without in_valid must not close a word.
    in_last = 1'b1;
    @(posedge core_clk);
    #1;
    in_last = 1'b0;
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    wait_drain();
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH; i++) send(IW'(i + 32'h1000), 1'b0);
    @(negedge core_clk);
    checks++;
    if (count !== CW'(DEPTH) || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full: count=%0d in_ready=%b required %0d 0", count, in_ready, DEPTH);
    end
    @(posedge core_clk);
    #1;
    in_data  = 32'hDEAD;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge core_clk);
      checks++;
      if (in_ready !== 1'b0 || count !== CW'(DEPTH)) begin
        errors++;
        $display("FAIL full_hold: in_ready=%b count=%0d required 0 %0d", in_ready, count, DEPTH);
      end
      @(posedge core_clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge core_clk);
    #1;
    out_ready = 1'b0;
    @(negedge core_clk);
    checks++;
    if (in_ready !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL one_pop: in_ready=%b count=%0d required 1 %0d", in_ready, count, DEPTH - 1);
    end
    @(posedge core_clk);
    #1;
  endtask

  task automatic test_commit_and_pop();
    in_data   = 32'h5A;
    in_last   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge core_clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || count !== CW'(DEPTH - 1)) begin
      errors++;
      $display("FAIL pre_simul: in_ready=%b out_valid=%b count=%0d required 1 1 %0d",
               in_ready, out_valid, count, DEPTH - 1);
    end
    if (in_ready) model_accept(32'h5A, 1'b1);
    @(posedge core_clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    @(negedge core_clk);
    checks++;
    if (count !== CW'(DEPTH - 1) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL simul_commit_pop: count=%0d in_ready=%b required %0d 1",
               count, in_ready, DEPTH - 1);
    end
    @(posedge core_clk);
    #1;
    wait_drain();
  endtask

  task automatic test_back_to_back_random();
    bit stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6 * DEPTH; i++) send(IW'(i), 1'b0);
        stream_done = 1'b1;
      end
      begin
        out_ready = 1'($urandom_range(0, 1));
        while (!stream_done) begin
          @(posedge core_clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(32'h5, 1'b0);
    resetn = 1'b0;
    @(negedge core_clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b count=%0d required 0 0 0",
               in_ready, out_valid, count);
    end
    @(posedge core_clk);
    #1;
    resetn  = 1'b1;
    tb_asm  = '0;
    tb_lane = 0;
    exp_q.delete();
    send(32'h7, 1'b0);
    send(32'h8, 1'b0);
    @(negedge core_clk);
    @(negedge core_clk);
    @(negedge core_clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 64'h00000008_00000007) begin
      errors++;
      $display("FAIL after_reset_word: out_valid=%b out_data=%h required 1 0000000800000007",
               out_valid, out_data);
    end
    @(posedge core_clk);
    #1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_pack_full_word();
    test_last_early();
    test_full();
    test_commit_and_pop();
    test_back_to_back_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
